// File: rtl/uart_regif_v2.sv
// uart_regif_v2: APB UART register interface with byte strobes,
// registered response, W1C latched interrupts and FIFO push/pop.
// Ports:
//   clk_i, srst_i          clock, synchronous active-high reset
//   mreq_i .. mstrb_i      memory-side request (held until mack_o)
//   mack_o, mrdata_o,      registered one-cycle response
//   mresp_o                (error flag)
//   ctrl_o, clk_div_o,     configuration registers
//   cfg_o, intr_en_o
//   tx_count_i, rx_count_i FIFO occupancy
//   tx_*                   TX FIFO push handshake
//   rx_*                   RX FIFO pop handshake
//   intr_event_i, irq_o    interrupt event pulses, request output
module uart_regif_v2 #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int NUM_INTR = 4,
   parameter logic [DATA_WIDTH-1:0] CLK_DIV_RST = 'h2580,
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1,
   localparam int STRB_W = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  srst_i,
   input  logic                  mreq_i,
   input  logic [ADDR_WIDTH-1:0] maddr_i,
   input  logic                  mwe_i,
   input  logic [DATA_WIDTH-1:0] mwdata_i,
   input  logic [STRB_W-1:0]     mstrb_i,
   output logic                  mack_o,
   output logic [DATA_WIDTH-1:0] mrdata_o,
   output logic                  mresp_o,
   output logic [DATA_WIDTH-1:0] ctrl_o,
   output logic [DATA_WIDTH-1:0] clk_div_o,
   output logic [DATA_WIDTH-1:0] cfg_o,
   output logic [NUM_INTR-1:0]   intr_en_o,
   input  logic [CNT_W-1:0]      tx_count_i,
   input  logic [CNT_W-1:0]      rx_count_i,
   output logic [7:0]            tx_data_o,
   output logic                  tx_valid_o,
   input  logic                  tx_ready_i,
   input  logic [7:0]            rx_data_i,
   input  logic                  rx_valid_i,
   output logic                  rx_ready_o,
   input  logic [NUM_INTR-1:0]   intr_event_i,
   output logic                  irq_o
);

   localparam logic [3:0] W_CTRL  = 4'd0;
   localparam logic [3:0] W_DIV   = 4'd1;
   localparam logic [3:0] W_CFG   = 4'd2;
   localparam logic [3:0] W_TXC   = 4'd3;
   localparam logic [3:0] W_RXC   = 4'd4;
   localparam logic [3:0] W_TX    = 4'd5;
   localparam logic [3:0] W_RX    = 4'd6;
   localparam logic [3:0] W_EN    = 4'd7;
   localparam logic [3:0] W_STATE = 4'd8;

   logic [DATA_WIDTH-1:0] ctrl;
   logic [DATA_WIDTH-1:0] clk_div;
   logic [DATA_WIDTH-1:0] cfg;
   logic [NUM_INTR-1:0]   intr_en;
   logic [NUM_INTR-1:0]   intr_state;
   logic                  ack;
   logic                  resp;
   logic [DATA_WIDTH-1:0] rdata;

   logic                  acc;
   logic                  hit;
   logic [3:0]            word;
   logic                  fifo_empty;
   logic                  sel_ctrl;
   logic                  sel_div;
   logic                  sel_cfg;
   logic                  sel_txc;
   logic                  sel_rxc;
   logic                  sel_tx;
   logic                  sel_rx;
   logic                  sel_en;
   logic                  sel_state;
   logic                  err;
   logic                  wr;
   logic                  rd;
   logic [DATA_WIDTH-1:0] rd_val;
   logic [NUM_INTR-1:0]   en_next;
   logic [NUM_INTR-1:0]   clr;

   function automatic logic [DATA_WIDTH-1:0] merge(
      input logic [DATA_WIDTH-1:0] old,
      input logic [DATA_WIDTH-1:0] wd,
      input logic [STRB_W-1:0]     st
   );
      logic [DATA_WIDTH-1:0] res;
      res = old;
      for (int k = 0; k < STRB_W; k++) begin
         if (st[k]) res[8*k +: 8] = wd[8*k +: 8];
      end
      return res;
   endfunction

   // A request is taken once; the ack cycle blocks re-acceptance,
   // and reset suppresses any access presented alongside it.
   assign acc = mreq_i & ~ack & ~srst_i;

   assign word = maddr_i[5:2];
   assign hit  = (maddr_i[1:0] == 2'b00) &&
                 ((maddr_i >> 6) == '0);

   assign fifo_empty = (tx_count_i == '0) &&
                       (rx_count_i == '0);

   assign sel_ctrl  = hit && (word == W_CTRL);
   assign sel_div   = hit && (word == W_DIV);
   assign sel_cfg   = hit && (word == W_CFG);
   assign sel_txc   = hit && (word == W_TXC);
   assign sel_rxc   = hit && (word == W_RXC);
   assign sel_tx    = hit && (word == W_TX);
   assign sel_rx    = hit && (word == W_RX);
   assign sel_en    = hit && (word == W_EN);
   assign sel_state = hit && (word == W_STATE);

   always_comb begin
      err = 1'b1;
      unique case (1'b1)
         sel_ctrl,
         sel_en,
         sel_state: err = 1'b0;
         sel_div,
         sel_cfg:   err = mwe_i & ~fifo_empty;
         sel_txc,
         sel_rxc:   err = mwe_i;
         sel_tx:    err = ~mwe_i | ~mstrb_i[0] | ~tx_ready_i;
         sel_rx:    err = mwe_i | ~rx_valid_i;
         default:   err = 1'b1;
      endcase
   end

   assign wr = acc & mwe_i & ~err;
   assign rd = acc & ~mwe_i & ~err;

   always_comb begin
      rd_val = '0;
      unique case (1'b1)
         sel_ctrl:  rd_val = ctrl;
         sel_div:   rd_val = clk_div;
         sel_cfg:   rd_val = cfg;
         sel_txc:   rd_val = DATA_WIDTH'(tx_count_i);
         sel_rxc:   rd_val = DATA_WIDTH'(rx_count_i);
         sel_rx:    rd_val = DATA_WIDTH'(rx_data_i);
         sel_en:    rd_val = DATA_WIDTH'(intr_en);
         sel_state: rd_val = DATA_WIDTH'(intr_state);
         default:   rd_val = '0;
      endcase
   end

   // Per-bit strobe handling for the narrow interrupt registers:
   // bit i belongs to byte lane i/8.
   always_comb begin
      en_next = intr_en;
      clr     = '0;
      for (int i = 0; i < NUM_INTR; i++) begin
         if (mstrb_i[i/8]) en_next[i] = mwdata_i[i];
         clr[i] = wr & sel_state & mstrb_i[i/8] & mwdata_i[i];
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         ctrl       <= '0;
         clk_div    <= CLK_DIV_RST;
         cfg        <= '0;
         intr_en    <= '0;
         intr_state <= '0;
         ack        <= 1'b0;
         resp       <= 1'b0;
         rdata      <= '0;
      end else begin
         ack   <= acc;
         resp  <= acc & err;
         rdata <= rd ? rd_val : '0;
         if (wr && sel_ctrl)
            ctrl <= merge(ctrl, mwdata_i, mstrb_i);
         if (wr && sel_div)
            clk_div <= merge(clk_div, mwdata_i, mstrb_i);
         if (wr && sel_cfg)
            cfg <= merge(cfg, mwdata_i, mstrb_i);
         if (wr && sel_en)
            intr_en <= en_next;
         // New events take priority over a same-cycle clear.
         intr_state <= (intr_state & ~clr) | intr_event_i;
      end
   end

   assign mack_o     = ack;
   assign mresp_o    = resp;
   assign mrdata_o   = rdata;
   assign ctrl_o     = ctrl;
   assign clk_div_o  = clk_div;
   assign cfg_o      = cfg;
   assign intr_en_o  = intr_en;
   assign tx_valid_o = wr & sel_tx;
   assign tx_data_o  = mwdata_i[7:0];
   assign rx_ready_o = rd & sel_rx;
   assign irq_o      = |(intr_state & intr_en);

endmodule

// File: tb/tb_uart_regif_v2.sv
// tb_uart_regif_v2: scoreboard bench for uart_regif_v2 with a
// behavioural register model and randomized accesses.
module tb_uart_regif_v2;

   logic        clk = 1'b0;
   logic        srst = 1'b1;
   logic        mreq = 1'b0;
   logic [7:0]  maddr = '0;
   logic        mwe = 1'b0;
   logic [31:0] mwdata = '0;
   logic [3:0]  mstrb = '0;
   logic [4:0]  txc = '0;
   logic [4:0]  rxc = '0;
   logic        tx_ready = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [3:0]  ev = '0;

   logic        mack;
   logic [31:0] mrdata;
   logic        mresp;
   logic [31:0] ctrl;
   logic [31:0] clk_div;
   logic [31:0] cfg;
   logic [3:0]  intr_en;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        rx_ready;
   logic        irq;

   uart_regif_v2 dut (
      .clk_i        (clk),
      .srst_i       (srst),
      .mreq_i       (mreq),
      .maddr_i      (maddr),
      .mwe_i        (mwe),
      .mwdata_i     (mwdata),
      .mstrb_i      (mstrb),
      .mack_o       (mack),
      .mrdata_o     (mrdata),
      .mresp_o      (mresp),
      .ctrl_o       (ctrl),
      .clk_div_o    (clk_div),
      .cfg_o        (cfg),
      .intr_en_o    (intr_en),
      .tx_count_i   (txc),
      .rx_count_i   (rxc),
      .tx_data_o    (tx_data),
      .tx_valid_o   (tx_valid),
      .tx_ready_i   (tx_ready),
      .rx_data_i    (rx_data),
      .rx_valid_i   (rx_valid),
      .rx_ready_o   (rx_ready),
      .intr_event_i (ev),
      .irq_o        (irq)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int issued = 0;
   int acks = 0;

   logic [31:0] exp_rd[$];
   logic        exp_resp[$];

   logic [31:0] m_ctrl;
   logic [31:0] m_div;
   logic [31:0] m_cfg;
   logic [3:0]  m_en;
   logic [3:0]  m_st;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Response monitor: pops the scoreboard on every ack.
   logic        prev_ack = 1'b0;
   logic [31:0] mon_rd;
   logic        mon_resp;

   always @(negedge clk) begin
      if (mack === 1'b1) begin
         acks++;
         chk("ack_spacing", {31'b0, prev_ack}, 32'd0);
         if (exp_rd.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack want none at %0t",
                     $time);
         end else begin
            mon_rd   = exp_rd.pop_front();
            mon_resp = exp_resp.pop_front();
            chk("rdata", mrdata, mon_rd);
            chk("resp", {31'b0, mresp}, {31'b0, mon_resp});
         end
      end else begin
         chk("idle_rdata", mrdata, 32'd0);
         chk("idle_resp", {31'b0, mresp}, 32'd0);
      end
      prev_ack = mack;
   end

   function automatic logic [31:0] merge(input logic [31:0] o,
                                         input logic [31:0] w,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int k = 0; k < 4; k++)
         if (s[k]) r[8*k +: 8] = w[8*k +: 8];
      return r;
   endfunction

   function automatic logic model_err(input logic [7:0] a,
                                      input logic we,
                                      input logic [3:0] s);
      if (a[1:0] != 2'b00 || a > 8'h20) return 1'b1;
      case (a)
         8'h04, 8'h08: return we && (txc != 0 || rxc != 0);
         8'h0C, 8'h10: return we;
         8'h14:        return !we || !s[0] || !tx_ready;
         8'h18:        return we || !rx_valid;
         default:      return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] a);
      case (a)
         8'h00:   return m_ctrl;
         8'h04:   return m_div;
         8'h08:   return m_cfg;
         8'h0C:   return {27'b0, txc};
         8'h10:   return {27'b0, rxc};
         8'h18:   return {24'b0, rx_data};
         8'h1C:   return {28'b0, m_en};
         8'h20:   return {28'b0, m_st};
         default: return 32'd0;
      endcase
   endfunction

   task automatic check_outputs();
      chk("ctrl_o", ctrl, m_ctrl);
      chk("clk_div_o", clk_div, m_div);
      chk("cfg_o", cfg, m_cfg);
      chk("intr_en_o", {28'b0, intr_en}, {28'b0, m_en});
      chk("irq_o", {31'b0, irq}, {31'b0, |(m_st & m_en)});
   endtask

   // Leaves mreq high in the ack cycle so a held request
   // is seen not to be re-accepted.
   task automatic access(input logic [7:0] a,
                         input logic we,
                         input logic [31:0] wd,
                         input logic [3:0] s,
                         input logic [3:0] e);
      logic        er;
      logic [3:0]  c;
      mreq   = 1'b1;
      maddr  = a;
      mwe    = we;
      mwdata = wd;
      mstrb  = s;
      if (mack === 1'b1) begin
         @(posedge clk);
         #1;
      end
      ev = e;
      er = model_err(a, we, s);
      exp_rd.push_back((er || we) ? 32'd0 : model_read(a));
      exp_resp.push_back(er);
      issued++;
      #1;
      chk("tx_valid", {31'b0, tx_valid},
          {31'b0, (we && a == 8'h14 && !er)});
      if (we && a == 8'h14 && !er)
         chk("tx_data", {24'b0, tx_data}, {24'b0, wd[7:0]});
      chk("rx_ready", {31'b0, rx_ready},
          {31'b0, (!we && a == 8'h18 && !er)});
      @(posedge clk);
      #1;
      ev = '0;
      c = '0;
      if (we && !er) begin
         case (a)
            8'h00: m_ctrl = merge(m_ctrl, wd, s);
            8'h04: m_div  = merge(m_div, wd, s);
            8'h08: m_cfg  = merge(m_cfg, wd, s);
            8'h1C: if (s[0]) m_en = wd[3:0];
            8'h20: if (s[0]) c = wd[3:0];
            default: ;
         endcase
      end
      m_st = (m_st & ~c) | e;
      check_outputs();
      chk("held_tx_valid", {31'b0, tx_valid}, 32'd0);
      chk("held_rx_ready", {31'b0, rx_ready}, 32'd0);
   endtask

   task automatic idle(input int n);
      mreq = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic [3:0] e);
      mreq = 1'b0;
      ev   = e;
      @(posedge clk);
      #1;
      ev   = '0;
      m_st = m_st | e;
      chk("irq_after_event", {31'b0, irq}, {31'b0, |(m_st & m_en)});
   endtask

   task automatic do_reset(input logic pending);
      mreq   = pending;
      maddr  = 8'h00;
      mwe    = 1'b1;
      mwdata = 32'hFFFF_FFFF;
      mstrb  = 4'hF;
      ev     = 4'hF;
      srst   = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      srst   = 1'b0;
      mreq   = 1'b0;
      ev     = '0;
      m_ctrl = '0;
      m_div  = 32'h2580;
      m_cfg  = '0;
      m_en   = '0;
      m_st   = '0;
      check_outputs();
      chk("reset_ack", {31'b0, mack}, 32'd0);
   endtask

   logic [7:0] ra;

   initial begin
      do_reset(1'b1);
      idle(1);

      access(8'h04, 1'b0, 32'd0, 4'h0, 4'h0);
      access(8'h00, 1'b1, 32'hAABBCCDD, 4'b0101, 4'h0);
      chk("strobe_ctrl", ctrl, 32'h00BB00DD);
      txc = 5'd3;
      access(8'h04, 1'b1, 32'h1234, 4'hF, 4'h0);
      txc = 5'd0;
      access(8'h08, 1'b1, 32'h0000_00FF, 4'b0001, 4'h0);
      access(8'h04, 1'b1, 32'h0000_0000, 4'b0000, 4'h0);

      tx_ready = 1'b1;
      access(8'h14, 1'b1, 32'h0000_005A, 4'h1, 4'h0);
      tx_ready = 1'b0;
      access(8'h14, 1'b1, 32'h0000_005A, 4'h1, 4'h0);

      rx_valid = 1'b1;
      rx_data  = 8'h3C;
      access(8'h18, 1'b0, 32'd0, 4'h0, 4'h0);
      rx_valid = 1'b0;
      access(8'h18, 1'b0, 32'd0, 4'h0, 4'h0);

      access(8'h1C, 1'b1, 32'h3, 4'h1, 4'h0);
      pulse(4'b0010);
      chk("irq_set", {31'b0, irq}, 32'd1);
      access(8'h20, 1'b0, 32'd0, 4'h0, 4'h0);
      access(8'h20, 1'b1, 32'h2, 4'h1, 4'b0010);
      access(8'h20, 1'b0, 32'd0, 4'h0, 4'h0);
      access(8'h20, 1'b1, 32'h2, 4'h1, 4'h0);
      chk("irq_cleared", {31'b0, irq}, 32'd0);

      access(8'h24, 1'b0, 32'd0, 4'h0, 4'h0);
      access(8'h02, 1'b1, 32'hFFFF, 4'hF, 4'h0);
      access(8'h14, 1'b0, 32'd0, 4'h0, 4'h0);
      access(8'h0C, 1'b1, 32'd1, 4'hF, 4'h0);
      idle(1);

      for (int i = 0; i < 6; i++)
         access(8'h08, 1'b1, $urandom, 4'hF, 4'h0);
      idle(2);

      for (int i = 0; i < 400; i++) begin
         case ($urandom % 8)
            6:       ra = 8'($urandom);
            7:       ra = 8'(($urandom % 9) * 4 + $urandom_range(1, 3));
            default: ra = 8'(($urandom % 9) * 4);
         endcase
         txc      = ($urandom % 3 == 0) ? 5'($urandom_range(0, 16)) : 5'd0;
         rxc      = ($urandom % 3 == 0) ? 5'($urandom_range(0, 16)) : 5'd0;
         tx_ready = 1'($urandom);
         rx_valid = 1'($urandom);
         rx_data  = 8'($urandom);
         access(ra, 1'($urandom), $urandom, 4'($urandom),
                ($urandom % 4 == 0) ? 4'($urandom) : 4'h0);
         case ($urandom % 16)
            0:       idle(1);
            1:       pulse(4'($urandom));
            2:       if ($urandom % 4 == 0) do_reset(1'($urandom));
            default: ;
         endcase
      end

      idle(3);
      chk("scoreboard_empty", exp_rd.size(), 32'd0);
      chk("ack_count", acks, issued);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
